// File: rtl/sram_bank_ctrl.sv
// Byte-port controller for a banked async SRAM: bank/lane decode, CE_n/WE_n/OE_n timing, wait states.
// Optional SRAM_BACK2BACK_EN lets HOLD take a new request directly (no IDLE gap).
module sram_bank_ctrl #(
    parameter int ADDR_W      = 21,
    parameter int SRAM_A_W    = 19,
    parameter int NUM_BANKS   = 4,
    parameter int SRAM_D_W    = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [7:0]              wdata,
    output logic                    ack,
    output logic [7:0]              rdata,
    output logic                    busy,
    output logic [SRAM_A_W-1:0]     SRAM_A,
    output logic [SRAM_D_W-1:0]     SRAM_D_o,
    output logic [SRAM_D_W/8-1:0]   SRAM_D_oe,
    input  logic [SRAM_D_W-1:0]     SRAM_D_i,
    output logic                    SRAM_WE_n,
    output logic                    SRAM_OE_n,
    output logic [NUM_BANKS-1:0]    SRAM_CE_n
);

    localparam int LANES  = SRAM_D_W / 8;
    localparam int BANK_W = ADDR_W - SRAM_A_W;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt;
    logic               take;
    logic               lat_we;
    logic [BANK_W-1:0]  lat_bank;
    logic               we_nxt;
    logic [BANK_W-1:0]  bank_nxt;
    logic [NUM_BANKS-1:0] ce_nxt;
    logic [LANES-1:0]   lane_hit;
    logic [7:0]         rd_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == ACCESS && state != ACCESS)
                cnt <= 4'(WAIT_STATES);
            else if (state == ACCESS && cnt != 4'd0)
                cnt <= cnt - 4'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            IDLE: if (req) begin
                take      = 1'b1;
                state_nxt = SETUP;
            end
            SETUP:  state_nxt = ACCESS;
            ACCESS: if (cnt == 4'd0) state_nxt = HOLD;
            HOLD: begin
`ifdef SRAM_BACK2BACK_EN
                if (req) begin
                    take      = 1'b1;
                    state_nxt = SETUP;
                end else begin
                    state_nxt = IDLE;
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pins are registered from the next-state view so they line up with the state they belong to.
    always_comb begin
        we_nxt   = take ? we : lat_we;
        bank_nxt = take ? addr[ADDR_W-1:SRAM_A_W] : lat_bank;
        for (int b = 0; b < NUM_BANKS; b++)
            ce_nxt[b] = !(state_nxt != IDLE && bank_nxt == BANK_W'(b));
        for (int l = 0; l < LANES; l++)
            lane_hit[l] = (int'(bank_nxt) % LANES) == l;
        rd_byte = '0;
        for (int l = 0; l < LANES; l++)
            if ((int'(lat_bank) % LANES) == l) rd_byte = SRAM_D_i[l*8 +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack       <= 1'b0;
            busy      <= 1'b0;
            rdata     <= '0;
            lat_we    <= 1'b0;
            lat_bank  <= '0;
            SRAM_A    <= '0;
            SRAM_D_o  <= '0;
            SRAM_D_oe <= '0;
            SRAM_WE_n <= 1'b1;
            SRAM_OE_n <= 1'b1;
            SRAM_CE_n <= '1;
        end else begin
            if (take) begin
                lat_we   <= we;
                lat_bank <= addr[ADDR_W-1:SRAM_A_W];
                SRAM_A   <= addr[SRAM_A_W-1:0];
                SRAM_D_o <= {LANES{wdata}};
            end
            SRAM_CE_n <= ce_nxt;
            SRAM_D_oe <= (state_nxt != IDLE && we_nxt) ? lane_hit : '0;
            SRAM_WE_n <= !(state_nxt == ACCESS && lat_we);
            SRAM_OE_n <= !(state_nxt == ACCESS && !lat_we);
            ack       <= state_nxt == HOLD;
            busy      <= state_nxt != IDLE;
            if (state == ACCESS && cnt == 4'd0 && !lat_we)
                rdata <= rd_byte;
        end
    end

endmodule
